cache_stats: RTL

- Statistics collector that sits directly downstream of the cache model.
- Consumes one per-access event record from the cache per cycle and accumulates eight saturating counters.
- On request, snapshots the counters and dumps them serially over a valid/ready report port, which feeds the end-of-run summary printer.
- Replaces hierarchical peeking into cache counter variables with a clean, verifiable interface.

---
 rtl/cache_stats_pkg.sv | 29 ++
 rtl/cache_stats_if.sv | 34 +++
 rtl/cache_stats_sat_counter.sv | 25 ++
 rtl/cache_stats.sv | 102 ++++++++++
 4 files changed

// File: rtl/cache_stats_pkg.sv
// Shared types and constants for the cache statistics collector.
package cache_stats_pkg;

    localparam int NUM_CNT = 8;

    typedef enum logic [1:0] {
        READ  = 2'd0,
        WRITE = 2'd1,
        INVAL = 2'd2
    } access_type_e;

    typedef enum logic [2:0] {
        ID_ACCESSES   = 3'd0,
        ID_READS      = 3'd1,
        ID_WRITES     = 3'd2,
        ID_INVALS     = 3'd3,
        ID_HITS       = 3'd4,
        ID_MISSES     = 3'd5,
        ID_EVICTIONS  = 3'd6,
        ID_WRITEBACKS = 3'd7
    } stats_id_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DUMP = 2'd1,
        DONE = 2'd2
    } rpt_state_e;

endpackage

// File: rtl/cache_stats_if.sv
// Event-in / report-out bus between the cache model, the stats block and
// the summary printer. The master side is the cache plus report consumer.
interface cache_stats_if #(
    parameter int CNT_W = 32
);
    import cache_stats_pkg::*;

    logic             ev_valid;
    logic [1:0]       ev_type;
    logic             ev_hit;
    logic             ev_evict;
    logic             ev_wb;
    logic             clr;
    logic             rpt_start;
    logic             rpt_valid;
    logic             rpt_ready;
    logic [2:0]       rpt_id;
    logic [CNT_W-1:0] rpt_data;
    logic             rpt_last;
    logic             rpt_done;
    logic             busy;
    logic             err_type;

    modport master (
        output ev_valid, ev_type, ev_hit, ev_evict, ev_wb, clr, rpt_start, rpt_ready,
        input  rpt_valid, rpt_id, rpt_data, rpt_last, rpt_done, busy, err_type
    );

    modport slave (
        input  ev_valid, ev_type, ev_hit, ev_evict, ev_wb, clr, rpt_start, rpt_ready,
        output rpt_valid, rpt_id, rpt_data, rpt_last, rpt_done, busy, err_type
    );

endinterface

// File: rtl/cache_stats_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] r_cnt;

    // clear has priority over increment; stop at max instead of wrapping
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (inc && !(&r_cnt)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/cache_stats.sv
// Cache statistics collector: eight live saturating counters fed by the
// per-access event stream, plus a snapshot that is dumped word by word.
module cache_stats
    import cache_stats_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    cache_stats_if.slave  bus
);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_DUMP = DUMP;
    localparam logic [1:0] S_DONE = DONE;

    logic [NUM_CNT-1:0] w_inc;
    logic               w_is_acc;
    logic               w_is_inv;
    logic [CNT_W-1:0]   w_cnt      [NUM_CNT];
    logic [CNT_W-1:0]   w_cnt_next [NUM_CNT];
    logic [CNT_W-1:0]   r_snap     [NUM_CNT];
    logic [1:0]         r_state;
    logic [2:0]         r_id;
    logic               r_err;

    // decode one event record into per-counter increment strobes
    always_comb begin
        w_inc    = '0;
        w_is_acc = bus.ev_valid && (bus.ev_type == READ || bus.ev_type == WRITE);
        w_is_inv = bus.ev_valid && (bus.ev_type == INVAL);
        w_inc[ID_ACCESSES]   = w_is_acc;
        w_inc[ID_READS]      = w_is_acc && (bus.ev_type == READ);
        w_inc[ID_WRITES]     = w_is_acc && (bus.ev_type == WRITE);
        w_inc[ID_INVALS]     = w_is_inv;
        w_inc[ID_HITS]       = w_is_acc && bus.ev_hit;
        w_inc[ID_MISSES]     = w_is_acc && !bus.ev_hit;
        w_inc[ID_EVICTIONS]  = (w_is_acc || w_is_inv) && bus.ev_evict;
        w_inc[ID_WRITEBACKS] = (w_is_acc || w_is_inv) && bus.ev_wb;
    end

    // live counters, plus a look-ahead of their next value so the snapshot
    // taken on rpt_start already includes the same-cycle event (or clear)
    for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
        sat_counter #(.W(CNT_W)) u_cnt (
            .clk (clk),
            .rst (rst),
            .clr (bus.clr),
            .inc (w_inc[g]),
            .cnt (w_cnt[g])
        );

        assign w_cnt_next[g] = bus.clr                       ? '0 :
                               (w_inc[g] && !(&w_cnt[g]))    ? w_cnt[g] + CNT_W'(1) :
                                                               w_cnt[g];
    end

    // report FSM: snapshot on start, walk ids 0..7 under valid/ready, pulse done
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_id    <= '0;
            for (int i = 0; i < NUM_CNT; i++) r_snap[i] <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.rpt_start) begin
                        r_snap  <= w_cnt_next;
                        r_id    <= '0;
                        r_state <= S_DUMP;
                    end
                end
                S_DUMP: begin
                    if (bus.rpt_ready) begin
                        if (r_id == 3'(ID_WRITEBACKS)) r_state <= S_DONE;
                        else                           r_id    <= r_id + 3'd1;
                    end
                end
                S_DONE: begin
                    r_id    <= '0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // sticky flag for the reserved event type; only reset clears it
    always_ff @(posedge clk) begin
        if (rst)                                    r_err <= 1'b0;
        else if (bus.ev_valid && bus.ev_type == 2'd3) r_err <= 1'b1;
    end

    assign bus.rpt_valid = (r_state == S_DUMP);
    assign bus.busy      = (r_state == S_DUMP);
    assign bus.rpt_done  = (r_state == S_DONE);
    assign bus.rpt_last  = (r_state == S_DUMP) && (r_id == 3'(ID_WRITEBACKS));
    assign bus.rpt_id    = r_id;
    assign bus.rpt_data  = r_snap[r_id];
    assign bus.err_type  = r_err;

endmodule
